// File: rtl/fetch_queue_pkg.sv
// Shared front-end types: IF/ID packet payload and fetch-queue sizing.
package fetch_queue_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned FQ_DEPTH = 8;
  localparam int unsigned FQ_SKID  = 4;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] npc;
    logic [XLEN-1:0] inst;
    logic            bp_hit;
    logic [1:0]      bp_state;
  } If_id_pkt_t;

endpackage

// File: rtl/fetch_queue_mem.sv
// Fetch-queue entry storage: DEPTH x If_id_pkt_t, two write ports, two
// asynchronous read ports, no reset on data.
module fetchq_mem
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = FQ_DEPTH,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we0,
  input  logic [AW-1:0] wa0,
  input  If_id_pkt_t    wd0,
  input  logic          we1,
  input  logic [AW-1:0] wa1,
  input  If_id_pkt_t    wd1,
  input  logic [AW-1:0] ra0,
  input  logic [AW-1:0] ra1,
  output If_id_pkt_t    rd0,
  output If_id_pkt_t    rd1
);

  If_id_pkt_t mem [DEPTH];

  // Write both ports; the queue never targets the same index twice in a cycle.
  always_ff @(posedge clk) begin
    if (we0) mem[wa0] <= wd0;
    if (we1) mem[wa1] <= wd1;
  end

  assign rd0 = mem[ra0];
  assign rd1 = mem[ra1];

endmodule

// File: rtl/fetch_queue.sv
// Fetch queue between IF and ID: two-wide enqueue of compacted valid slots,
// two-wide in-order dequeue, stall-replay suppression and flush.
// Optional macro FETCHQ_BYPASS_EN: when empty, incoming slots are shown to
// decode in the same cycle and only the unconsumed ones are stored.
// DEPTH must be a power of two and at least 4.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = FQ_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  If_id_pkt_t [1:0]      in_pkt,
  output logic [1:0]            fq_stall,
  output If_id_pkt_t [1:0]      out_pkt,
  output logic [1:0]            out_valid,
  input  logic [1:0]            deq,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head, tail;
  logic [XLEN-1:0]  last_pc;
  logic             last_vld;

  If_id_pkt_t [1:0] cmp;
  logic [1:0]       in_n;
  logic [CNT_W-1:0] free;
  logic             replay;
  logic             enq_ok;
  logic [1:0]       enq_n;

  If_id_pkt_t       rd0, rd1;
  If_id_pkt_t [1:0] view_pkt;
  logic [1:0]       view_n;
  logic             byp;

  logic [1:0]       deq_n;
  logic [1:0]       skip;
  logic [1:0]       wr_n;
  logic [1:0]       ret_n;
  logic             we0, we1;
  If_id_pkt_t       wd0;

  // Compact valid input slots toward slot 0, preserving age order.
  always_comb begin
    cmp  = '0;
    in_n = 2'd0;
    case ({in_pkt[1].valid, in_pkt[0].valid})
      2'b11: begin cmp = in_pkt;       in_n = 2'd2; end
      2'b01: begin cmp[0] = in_pkt[0]; in_n = 2'd1; end
      2'b10: begin cmp[0] = in_pkt[1]; in_n = 2'd1; end
      default: ;
    endcase
  end

  assign free   = CNT_W'(DEPTH) - count;
  assign replay = last_vld && in_pkt[0].valid && (in_pkt[0].pc == last_pc);
  // Whole packet accepted only if it fits before this cycle's dequeue.
  assign enq_ok = !rst && !flush && (in_n != 2'd0) && !replay &&
                  (free >= CNT_W'(in_n));
  assign enq_n  = enq_ok ? in_n : 2'd0;

  assign fq_stall = {1'b0, (free < CNT_W'(FQ_SKID))};

  // Decode view: two oldest stored entries, or the incoming packet on bypass.
  always_comb begin
    view_pkt = {rd1, rd0};
    if (count >= CNT_W'(2)) view_n = 2'd2;
    else                    view_n = count[1:0];
    byp = 1'b0;
`ifdef FETCHQ_BYPASS_EN
    if ((count == '0) && enq_ok) begin
      byp      = 1'b1;
      view_pkt = cmp;
      view_n   = enq_n;
    end
`endif
  end

  assign out_valid  = (view_n == 2'd2) ? 2'b11 : ((view_n == 2'd1) ? 2'b01 : 2'b00);
  assign out_pkt[0] = out_valid[0] ? view_pkt[0] : '0;
  assign out_pkt[1] = out_valid[1] ? view_pkt[1] : '0;

  // Dequeue amount: deq[1] implies both slots; clipped to what is visible.
  always_comb begin
    deq_n = 2'd0;
    if (deq[1])      deq_n = view_n;
    else if (deq[0]) deq_n = (view_n != 2'd0) ? 2'd1 : 2'd0;
    if (flush || rst) deq_n = 2'd0;
  end

  // Bypassed slots consumed this cycle are never written to storage.
  always_comb begin
    skip  = byp ? deq_n : 2'd0;
    ret_n = byp ? 2'd0 : deq_n;
    wr_n  = enq_n - skip;
    we0   = (wr_n != 2'd0);
    we1   = (wr_n == 2'd2);
    wd0   = (skip == 2'd1) ? cmp[1] : cmp[0];
  end

  fetchq_mem #(
    .DEPTH (DEPTH),
    .AW    (PTR_W)
  ) u_mem (
    .clk (clk),
    .we0 (we0),
    .wa0 (tail),
    .wd0 (wd0),
    .we1 (we1),
    .wa1 (tail + PTR_W'(1)),
    .wd1 (cmp[1]),
    .ra0 (head),
    .ra1 (head + PTR_W'(1)),
    .rd0 (rd0),
    .rd1 (rd1)
  );

  // Pointer, occupancy and replay-tracking state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      last_vld <= 1'b0;
      last_pc  <= '0;
    end else if (flush) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      last_vld <= 1'b0;
    end else begin
      head  <= head + PTR_W'(ret_n);
      tail  <= tail + PTR_W'(wr_n);
      count <= count + CNT_W'(wr_n) - CNT_W'(ret_n);
      if (enq_ok && in_pkt[0].valid) begin
        last_pc  <= in_pkt[0].pc;
        last_vld <= 1'b1;
      end
    end
  end

endmodule
